// File: rtl/secuenciador_melodia_if.sv
// Control and speaker bus of the melody sequencer: play/stop requests, note ROM
// port and the buzzer/status outputs. Signal prefixes are from the sequencer's side.
interface secuenciador_melodia_if;
  logic        i_play;
  logic        i_stop;
  logic [4:0]  o_direccion_nota;
  logic [15:0] i_ciclos_de_nota;
  logic        o_buzzer;
  logic        o_busy;
  logic        o_nota_fin;
  logic        o_done;

  modport slave (
    input  i_play,
    input  i_stop,
    input  i_ciclos_de_nota,
    output o_direccion_nota,
    output o_buzzer,
    output o_busy,
    output o_nota_fin,
    output o_done
  );

  modport master (
    output i_play,
    output i_stop,
    output i_ciclos_de_nota,
    input  o_direccion_nota,
    input  o_buzzer,
    input  o_busy,
    input  o_nota_fin,
    input  o_done
  );
endinterface

// File: rtl/secuenciador_melodia.sv
// Melody sequencer: walks the note ROM, sounds each note as a square wave, then a gap.
// Define MELODIA_LOOP_EN to replay the melody endlessly instead of ending with done.
module secuenciador_melodia #(
  parameter int NUM_NOTAS  = 25,
  parameter int DUR_CICLOS = 3_000_000,
  parameter int GAP_CICLOS = 600_000,
  parameter int DUR_W      = 22
) (
  input logic i_clk,
  input logic i_rst_n,
  secuenciador_melodia_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_PLAY,
    S_GAP
  } state_t;

  localparam logic [DUR_W-1:0] LP_DUR_FIN = DUR_W'(DUR_CICLOS - 1);
  localparam logic [DUR_W-1:0] LP_GAP_FIN = DUR_W'(GAP_CICLOS - 1);
  localparam logic [4:0]       LP_ULTIMA  = 5'(NUM_NOTAS - 1);

  state_t             r_state;
  logic [4:0]         r_direccion;
  logic [15:0]        r_periodo;
  logic [15:0]        r_half_cnt;
  logic [DUR_W-1:0]   r_dur_cnt;
  logic               r_buzzer;
  logic               r_busy;
  logic               r_nota_fin;
  logic               r_done;

  state_t             w_state;
  logic [4:0]         w_direccion;
  logic [15:0]        w_periodo;
  logic [15:0]        w_half_cnt;
  logic [DUR_W-1:0]   w_dur_cnt;
  logic               w_buzzer;
  logic               w_nota_fin;
  logic               w_done;

  // Every output is a register, so the next value of each is computed here.
  always_comb begin
    w_state     = r_state;
    w_direccion = r_direccion;
    w_periodo   = r_periodo;
    w_half_cnt  = r_half_cnt;
    w_dur_cnt   = r_dur_cnt;
    w_buzzer    = r_buzzer;
    w_nota_fin  = 1'b0;
    w_done      = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_buzzer    = 1'b0;
        w_direccion = 5'd0;
        w_half_cnt  = 16'd0;
        w_dur_cnt   = '0;
        if (bus.i_play && !bus.i_stop) begin
          w_state = S_LOAD;
        end
      end
      S_LOAD: begin
        w_periodo  = bus.i_ciclos_de_nota;
        w_half_cnt = 16'd0;
        w_dur_cnt  = '0;
        w_buzzer   = 1'b0;
        w_state    = S_PLAY;
      end
      S_PLAY: begin
        w_dur_cnt = r_dur_cnt + 1'b1;
        if (r_periodo != 16'd0) begin
          if (r_half_cnt == r_periodo - 16'd1) begin
            w_buzzer   = ~r_buzzer;
            w_half_cnt = 16'd0;
          end else begin
            w_half_cnt = r_half_cnt + 16'd1;
          end
        end else begin
          w_buzzer = 1'b0;
        end
        if (r_dur_cnt == LP_DUR_FIN) begin
          w_buzzer   = 1'b0;
          w_nota_fin = 1'b1;
          w_dur_cnt  = '0;
          w_state    = S_GAP;
        end
      end
      S_GAP: begin
        w_buzzer  = 1'b0;
        w_dur_cnt = r_dur_cnt + 1'b1;
        if (r_dur_cnt == LP_GAP_FIN) begin
          w_dur_cnt = '0;
          if (r_direccion == LP_ULTIMA) begin
            w_direccion = 5'd0;
`ifdef MELODIA_LOOP_EN
            w_state = S_LOAD;
`else
            w_done  = 1'b1;
            w_state = S_IDLE;
`endif
          end else begin
            w_direccion = r_direccion + 5'd1;
            w_state     = S_LOAD;
          end
        end
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase

    // Abort overrides whatever the active state decided, including any pulse.
    if (bus.i_stop && (r_state != S_IDLE)) begin
      w_state     = S_IDLE;
      w_direccion = 5'd0;
      w_half_cnt  = 16'd0;
      w_dur_cnt   = '0;
      w_buzzer    = 1'b0;
      w_nota_fin  = 1'b0;
      w_done      = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_direccion <= 5'd0;
      r_periodo   <= 16'd0;
      r_half_cnt  <= 16'd0;
      r_dur_cnt   <= '0;
      r_buzzer    <= 1'b0;
      r_busy      <= 1'b0;
      r_nota_fin  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_direccion <= w_direccion;
      r_periodo   <= w_periodo;
      r_half_cnt  <= w_half_cnt;
      r_dur_cnt   <= w_dur_cnt;
      r_buzzer    <= w_buzzer;
      r_busy      <= (w_state != S_IDLE);
      r_nota_fin  <= w_nota_fin;
      r_done      <= w_done;
    end
  end

  assign bus.o_direccion_nota = r_direccion;
  assign bus.o_buzzer         = r_buzzer;
  assign bus.o_busy           = r_busy;
  assign bus.o_nota_fin       = r_nota_fin;
  assign bus.o_done           = r_done;

endmodule

// File: tb/tb_secuenciador_melodia.sv
// Directed bench for secuenciador_melodia: 3-note stub ROM {4,0,7}, 100-clock notes,
// 10-clock gaps, so each note takes 111 clocks from LOAD entry.
module tb_secuenciador_melodia;

  localparam int NUM_NOTAS  = 3;
  localparam int DUR_CICLOS = 100;
  localparam int GAP_CICLOS = 10;
  localparam int NOTA_TOT   = 1 + DUR_CICLOS + GAP_CICLOS;
  localparam int PASE_TOT   = NUM_NOTAS * NOTA_TOT;
`ifdef MELODIA_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   nChecks;
  int   nFail;

  secuenciador_melodia_if bus ();

  secuenciador_melodia #(
    .NUM_NOTAS (NUM_NOTAS),
    .DUR_CICLOS(DUR_CICLOS),
    .GAP_CICLOS(GAP_CICLOS),
    .DUR_W     (22)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int rom_val(int n);
    case (n)
      0:       return 4;
      1:       return 0;
      2:       return 7;
      default: return 0;
    endcase
  endfunction

  always_comb bus.i_ciclos_de_nota = 16'(rom_val(int'(bus.o_direccion_nota)));

  // Buzzer level j clocks after entering PLAY: toggles every per clocks, rest stays low.
  function automatic logic exp_buzzer(int per, int j);
    if (per == 0) return 1'b0;
    return logic'((j / per) % 2);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    bus.i_play = 1'b1;
    bus.i_stop = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      nChecks++;
      if (bus.o_buzzer !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_direccion_nota !== 5'd0 ||
          bus.o_nota_fin !== 1'b0 || bus.o_done !== 1'b0) begin
        nFail++;
        $display("[TB] FAIL reset_hold cycle %0d: buzzer=%b busy=%b dir=%0d nf=%b done=%b, required all 0",
                 c, bus.o_buzzer, bus.o_busy, bus.o_direccion_nota, bus.o_nota_fin, bus.o_done);
      end
    end
    bus.i_play = 1'b0;
    rst_n      = 1'b1;
    tick();
    nChecks++;
    if (bus.o_busy !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL reset_release busy=%b, required 0", bus.o_busy);
    end
  endtask

  task automatic test_full_pass();
    int   n, o;
    logic eBuz, eBusy, eDone, eNf;
    logic [4:0] eDir;
    int   rises, nfCount, doneCount;
    logic prevBuz;
    rises = 0; nfCount = 0; doneCount = 0; prevBuz = 1'b0;
    bus.i_play = 1'b1;
    tick();
    nChecks++;
    if (bus.o_busy !== 1'b1 || bus.o_direccion_nota !== 5'd0) begin
      nFail++;
      $display("[TB] FAIL start busy=%b dir=%0d, required busy=1 dir=0", bus.o_busy, bus.o_direccion_nota);
    end
    bus.i_play = 1'b0;
    for (int t = 1; t <= PASE_TOT; t++) begin
      tick();
      n = t / NOTA_TOT;
      o = t % NOTA_TOT;
      if (t == PASE_TOT) begin
        eDir = 5'd0; eBusy = LOOP; eDone = !LOOP; eNf = 1'b0; eBuz = 1'b0;
      end else begin
        eDir  = 5'(n);
        eBusy = 1'b1;
        eDone = 1'b0;
        eNf   = (o == DUR_CICLOS + 1);
        eBuz  = (o >= 1 && o <= DUR_CICLOS) ? exp_buzzer(rom_val(n), o - 1) : 1'b0;
      end
      nChecks++;
      if (bus.o_buzzer !== eBuz) begin
        nFail++;
        $display("[TB] FAIL pass_buzzer t=%0d got %b, required %b", t, bus.o_buzzer, eBuz);
      end
      nChecks++;
      if (bus.o_direccion_nota !== eDir) begin
        nFail++;
        $display("[TB] FAIL pass_dir t=%0d got %0d, required %0d", t, bus.o_direccion_nota, eDir);
      end
      nChecks++;
      if (bus.o_busy !== eBusy) begin
        nFail++;
        $display("[TB] FAIL pass_busy t=%0d got %b, required %b", t, bus.o_busy, eBusy);
      end
      nChecks++;
      if (bus.o_nota_fin !== eNf) begin
        nFail++;
        $display("[TB] FAIL pass_nota_fin t=%0d got %b, required %b", t, bus.o_nota_fin, eNf);
      end
      nChecks++;
      if (bus.o_done !== eDone) begin
        nFail++;
        $display("[TB] FAIL pass_done t=%0d got %b, required %b", t, bus.o_done, eDone);
      end
      if (n == 0 && bus.o_buzzer === 1'b1 && prevBuz === 1'b0) rises++;
      prevBuz = bus.o_buzzer;
      if (bus.o_nota_fin === 1'b1) nfCount++;
      if (bus.o_done === 1'b1) doneCount++;
      // play raised during note 0's gap must be ignored
      if (t == DUR_CICLOS + 1) bus.i_play = 1'b1;
      if (t == DUR_CICLOS + 8) bus.i_play = 1'b0;
    end
    nChecks++;
    if (rises !== 12) begin
      nFail++;
      $display("[TB] FAIL note0_rises got %0d, required 12", rises);
    end
    nChecks++;
    if (nfCount !== 3) begin
      nFail++;
      $display("[TB] FAIL nota_fin_count got %0d, required 3", nfCount);
    end
    nChecks++;
    if (doneCount !== int'(!LOOP)) begin
      nFail++;
      $display("[TB] FAIL done_count got %0d, required %0d", doneCount, int'(!LOOP));
    end
    bus.i_stop = 1'b1;
    tick();
    bus.i_stop = 1'b0;
    tick();
  endtask

  task automatic test_stop();
    bus.i_play = 1'b1;
    tick();
    bus.i_play = 1'b0;
    for (int t = 1; t <= 2 * NOTA_TOT + 1 + 50; t++) tick();
    nChecks++;
    if (bus.o_buzzer !== 1'b1 || bus.o_direccion_nota !== 5'd2) begin
      nFail++;
      $display("[TB] FAIL pre_stop buzzer=%b dir=%0d, required buzzer=1 dir=2", bus.o_buzzer, bus.o_direccion_nota);
    end
    bus.i_stop = 1'b1;
    tick();
    bus.i_stop = 1'b0;
    nChecks++;
    if (bus.o_busy !== 1'b0 || bus.o_buzzer !== 1'b0 || bus.o_direccion_nota !== 5'd0 ||
        bus.o_nota_fin !== 1'b0 || bus.o_done !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL stop_abort busy=%b buzzer=%b dir=%0d nf=%b done=%b, required all 0",
               bus.o_busy, bus.o_buzzer, bus.o_direccion_nota, bus.o_nota_fin, bus.o_done);
    end
    for (int c = 0; c < 15; c++) begin
      tick();
      nChecks++;
      if (bus.o_busy !== 1'b0 || bus.o_nota_fin !== 1'b0 || bus.o_done !== 1'b0) begin
        nFail++;
        $display("[TB] FAIL stop_quiet c=%0d busy=%b nf=%b done=%b, required all 0",
                 c, bus.o_busy, bus.o_nota_fin, bus.o_done);
      end
    end
    bus.i_play = 1'b1;
    bus.i_stop = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      nChecks++;
      if (bus.o_busy !== 1'b0) begin
        nFail++;
        $display("[TB] FAIL play_and_stop c=%0d busy=%b, required 0", c, bus.o_busy);
      end
    end
    bus.i_play = 1'b0;
    bus.i_stop = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_play();
    bus.i_play = 1'b1;
    tick();
    bus.i_play = 1'b0;
    for (int t = 1; t <= 2 * NOTA_TOT + 1 + 7; t++) tick();
    nChecks++;
    if (bus.o_buzzer !== 1'b1 || bus.o_busy !== 1'b1 || bus.o_direccion_nota !== 5'd2) begin
      nFail++;
      $display("[TB] FAIL pre_reset buzzer=%b busy=%b dir=%0d, required 1 1 2",
               bus.o_buzzer, bus.o_busy, bus.o_direccion_nota);
    end
    rst_n = 1'b0;
    tick();
    nChecks++;
    if (bus.o_busy !== 1'b0 || bus.o_buzzer !== 1'b0 || bus.o_direccion_nota !== 5'd0 ||
        bus.o_nota_fin !== 1'b0 || bus.o_done !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL reset_mid_play busy=%b buzzer=%b dir=%0d nf=%b done=%b, required all 0",
               bus.o_busy, bus.o_buzzer, bus.o_direccion_nota, bus.o_nota_fin, bus.o_done);
    end
    rst_n = 1'b1;
    tick();
    nChecks++;
    if (bus.o_busy !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL after_reset busy=%b, required 0", bus.o_busy);
    end
  endtask

  task automatic test_back_to_back();
    bus.i_play = 1'b1;
    tick();
    for (int t = 1; t <= PASE_TOT + 1; t++) begin
      tick();
      if (t == NOTA_TOT) begin
        nChecks++;
        if (bus.o_direccion_nota !== 5'd1 || bus.o_busy !== 1'b1) begin
          nFail++;
          $display("[TB] FAIL held_play_note1 dir=%0d busy=%b, required 1 1", bus.o_direccion_nota, bus.o_busy);
        end
      end
      if (t == PASE_TOT) begin
        nChecks++;
        if (bus.o_done !== !LOOP || bus.o_busy !== LOOP) begin
          nFail++;
          $display("[TB] FAIL held_play_end done=%b busy=%b, required done=%b busy=%b",
                   bus.o_done, bus.o_busy, !LOOP, LOOP);
        end
      end
      if (t == PASE_TOT + 1) begin
        nChecks++;
        if (bus.o_busy !== 1'b1 || bus.o_direccion_nota !== 5'd0 || bus.o_done !== 1'b0) begin
          nFail++;
          $display("[TB] FAIL restart busy=%b dir=%0d done=%b, required 1 0 0",
                   bus.o_busy, bus.o_direccion_nota, bus.o_done);
        end
      end
    end
    bus.i_play = 1'b0;
    bus.i_stop = 1'b1;
    tick();
    bus.i_stop = 1'b0;
    nChecks++;
    if (bus.o_busy !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL final_stop busy=%b, required 0", bus.o_busy);
    end
  endtask

  initial begin
    nChecks    = 0;
    nFail      = 0;
    rst_n      = 1'b0;
    bus.i_play = 1'b0;
    bus.i_stop = 1'b0;
    test_reset();
    test_full_pass();
    test_stop();
    test_reset_mid_play();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
